// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Control FSM that steps an external 8-bit program counter. It clears the PC,
// requests instruction words from memory, and pulses the PC enable once per
// accepted word, using either the instruction length or a branch offset as
// the PC increment.
//
// Optional feature (macro PC_SEQ_TIMEOUT_EN):
//   Adds a fetch-wait counter, an ERR state and the sticky timeout_err output.
//   A fetch that sees mem_ready low for TIMEOUT_CYCLES consecutive cycles
//   aborts into ERR. Without the macro, FETCH waits indefinitely.
//
// Parameters:
//   TIMEOUT_CYCLES  maximum FETCH wait cycles before ERR (macro builds only)
//
// Ports:
//   clk            single clock, rising edge
//   reset          synchronous, active-low reset
//   start          begin sequencing from PC 0 (honoured in IDLE/HALTED/ERR)
//   halt           stop sequencing
//   mem_ready      memory holds the word at the current PC
//   instr_len      byte length of current instruction (0 treated as 1)
//   branch_valid   current instruction is a taken branch
//   branch_offset  two's-complement PC offset for taken branches
//   pc_clear       PC active-high clear
//   pc_enable      PC enable
//   pc_increment   PC increment, held between steps
//   mem_req        fetch request to instruction memory
//   busy           high in CLEAR, FETCH and STEP
//   fetch_count    completed PC steps since the last CLEAR, saturating
//   timeout_err    sticky fetch timeout flag (macro builds only)
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       halt,
  input  logic       mem_ready,
  input  logic [2:0] instr_len,
  input  logic       branch_valid,
  input  logic [7:0] branch_offset,
  output logic       pc_clear,
  output logic       pc_enable,
  output logic [7:0] pc_increment,
  output logic       mem_req,
  output logic       busy,
  output logic [7:0] fetch_count
`ifdef PC_SEQ_TIMEOUT_EN
  ,
  output logic       timeout_err
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    FETCH  = 3'd2,
    STEP   = 3'd3,
`ifdef PC_SEQ_TIMEOUT_EN
    ERR    = 3'd5,
`endif
    HALTED = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Set when halt arrives together with the accepted word, so the step that
  // word triggers still completes before stopping.
  logic halt_pend;

  // A TIMEOUT_CYCLES below 1 has no meaningful interpretation; nothing is
  // generated for it, the default build simply ignores the value.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_invalid
  end

`ifdef PC_SEQ_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) > 4) ?
                          $clog2(TIMEOUT_CYCLES + 1) : 4;
  logic [WAIT_W-1:0] wait_cnt;
`endif

  // Increment chosen for the accepted word: branch offset wins, otherwise the
  // zero-extended length with a zero length promoted to one byte.
  function automatic logic [7:0] step_size(input logic       bv,
                                           input logic [7:0] off,
                                           input logic [2:0] len);
    logic [7:0] inc;
    if (bv)
      inc = off;
    else if (len == 3'd0)
      inc = 8'd1;
    else
      inc = {5'b0, len};
    return inc;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_nxt = state;
    pc_clear  = 1'b0;
    pc_enable = 1'b0;
    mem_req   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        pc_clear  = 1'b1;
        busy      = 1'b1;
        state_nxt = FETCH;
      end
      FETCH: begin
        mem_req = 1'b1;
        busy    = 1'b1;
        // An accepted word always completes its step; halt only aborts a
        // fetch that is still waiting, and takes priority over a timeout.
        if (mem_ready)
          state_nxt = STEP;
        else if (halt)
          state_nxt = HALTED;
`ifdef PC_SEQ_TIMEOUT_EN
        else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1))
          state_nxt = ERR;
`endif
      end
      STEP: begin
        pc_enable = 1'b1;
        busy      = 1'b1;
        state_nxt = (halt || halt_pend) ? HALTED : FETCH;
      end
      HALTED: begin
        if (start) state_nxt = CLEAR;
      end
`ifdef PC_SEQ_TIMEOUT_EN
      ERR: begin
        if (start) state_nxt = CLEAR;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      halt_pend    <= 1'b0;
      pc_increment <= 8'd0;
      fetch_count  <= 8'd0;
`ifdef PC_SEQ_TIMEOUT_EN
      wait_cnt     <= '0;
      timeout_err  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;

      // Count is cleared on entry so it already reads zero during CLEAR.
      if (state_nxt == CLEAR)
        fetch_count <= 8'd0;

      // The word is accepted on this edge: latch its increment and count the
      // step so both are visible for the whole STEP cycle.
      if (state == FETCH && mem_ready) begin
        pc_increment <= step_size(branch_valid, branch_offset, instr_len);
        fetch_count  <= sat_inc8(fetch_count);
        halt_pend    <= halt;
      end else if (state == STEP) begin
        halt_pend    <= 1'b0;
      end

`ifdef PC_SEQ_TIMEOUT_EN
      // Counts only consecutive not-ready cycles of a single fetch.
      if (state == FETCH && !mem_ready && state_nxt == FETCH)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      else
        wait_cnt <= '0;

      if (state_nxt == ERR)
        timeout_err <= 1'b1;
      else if (state_nxt == CLEAR)
        timeout_err <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       halt;
  logic       mem_ready;
  logic [2:0] instr_len;
  logic       branch_valid;
  logic [7:0] branch_offset;
  logic       pc_clear;
  logic       pc_enable;
  logic [7:0] pc_increment;
  logic       mem_req;
  logic       busy;
  logic [7:0] fetch_count;
`ifdef PC_SEQ_TIMEOUT_EN
  logic       timeout_err;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.TIMEOUT_CYCLES(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .halt         (halt),
    .mem_ready    (mem_ready),
    .instr_len    (instr_len),
    .branch_valid (branch_valid),
    .branch_offset(branch_offset),
    .pc_clear     (pc_clear),
    .pc_enable    (pc_enable),
    .pc_increment (pc_increment),
    .mem_req      (mem_req),
    .busy         (busy),
    .fetch_count  (fetch_count)
`ifdef PC_SEQ_TIMEOUT_EN
    ,
    .timeout_err  (timeout_err)
`endif
  );

  // The program counter the sequencer controls: 8-bit, wraps modulo 256.
  logic [7:0] pc = 8'd0;
  always @(posedge clk) begin
    if (pc_clear)       pc <= 8'd0;
    else if (pc_enable) pc <= pc + pc_increment;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  // Reference rule for the increment of an accepted instruction word.
  function automatic int ref_inc(input logic bv, input logic [7:0] off, input logic [2:0] len);
    if (bv) return int'(off);
    if (len == 3'd0) return 1;
    return int'(len);
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    start = 0; halt = 0; mem_ready = 0; instr_len = 0;
    branch_valid = 0; branch_offset = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    tick(2);
    tests++;
    if ({pc_clear, pc_enable, mem_req, busy} !== 4'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 0000", {pc_clear, pc_enable, mem_req, busy});
    end
    tests++;
    if (pc_increment !== 8'd0 || fetch_count !== 8'd0) begin
      fails++;
      $display("FAIL reset_data: got inc=%h cnt=%h expected 00/00", pc_increment, fetch_count);
    end
`ifdef PC_SEQ_TIMEOUT_EN
    tests++;
    if (timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_timeout_err: got %b expected 0", timeout_err);
    end
`endif
    reset = 1;
    tick(2);
    tests++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || pc_clear !== 1'b0) begin
      fails++;
      $display("FAIL idle_hold: got busy=%b mem_req=%b clr=%b expected 0 0 0", busy, mem_req, pc_clear);
    end
  endtask

  task automatic test_basic();
    pulse_start();
    tests++;
    if (pc_clear !== 1'b1 || busy !== 1'b1 || mem_req !== 1'b0 || fetch_count !== 8'd0) begin
      fails++;
      $display("FAIL clear_cycle: got clr=%b busy=%b req=%b cnt=%h expected 1 1 0 00",
               pc_clear, busy, mem_req, fetch_count);
    end
    tick();
    tests++;
    if (pc_clear !== 1'b0 || mem_req !== 1'b1) begin
      fails++;
      $display("FAIL first_fetch: got clr=%b req=%b expected 0 1", pc_clear, mem_req);
    end
    mem_ready = 1; instr_len = 3'd5;
    tick();
    mem_ready = 0;
    tests++;
    if (pc_enable !== 1'b1 || pc_increment !== 8'd5 || fetch_count !== 8'd1 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL first_step: got en=%b inc=%h cnt=%h req=%b expected 1 05 01 0",
               pc_enable, pc_increment, fetch_count, mem_req);
    end
    tick();
    tests++;
    if (pc !== 8'd5 || pc_enable !== 1'b0 || mem_req !== 1'b1 || pc_increment !== 8'd5) begin
      fails++;
      $display("FAIL after_step: got pc=%h en=%b req=%b inc=%h expected 05 0 1 05",
               pc, pc_enable, mem_req, pc_increment);
    end
  endtask

  task automatic test_len_branch();
    mem_ready = 1; instr_len = 3'd0;
    tick();
    mem_ready = 0;
    tests++;
    if (pc_increment !== 8'd1) begin
      fails++;
      $display("FAIL zero_len: got inc=%h expected 01", pc_increment);
    end
    tick();
    mem_ready = 1; branch_valid = 1; branch_offset = 8'hFC; instr_len = 3'd3;
    tick();
    mem_ready = 0; branch_valid = 0;
    tests++;
    if (pc_increment !== 8'hFC) begin
      fails++;
      $display("FAIL branch_inc: got inc=%h expected fc", pc_increment);
    end
    tick();
    tests++;
    if (pc !== 8'd2 || fetch_count !== 8'd3) begin
      fails++;
      $display("FAIL branch_pc: got pc=%h cnt=%h expected 02 03", pc, fetch_count);
    end
  endtask

  task automatic test_halt();
    halt = 1; mem_ready = 0;
    tick();
    halt = 0;
    tests++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || pc_enable !== 1'b0 || fetch_count !== 8'd3) begin
      fails++;
      $display("FAIL halt_wait: got busy=%b req=%b en=%b cnt=%h expected 0 0 0 03",
               busy, mem_req, pc_enable, fetch_count);
    end
    tick(3);
    tests++;
    if (busy !== 1'b0 || fetch_count !== 8'd3 || pc !== 8'd2) begin
      fails++;
      $display("FAIL halted_hold: got busy=%b cnt=%h pc=%h expected 0 03 02", busy, fetch_count, pc);
    end
    pulse_start();
    tick();
    halt = 1; mem_ready = 1; instr_len = 3'd2;
    tick();
    halt = 0; mem_ready = 0;
    tests++;
    if (pc_enable !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL halt_with_ready_step: got en=%b busy=%b expected 1 1", pc_enable, busy);
    end
    tick();
    tests++;
    if (pc_enable !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0 || fetch_count !== 8'd1 || pc !== 8'd2) begin
      fails++;
      $display("FAIL halt_pending: got en=%b busy=%b req=%b cnt=%h pc=%h expected 0 0 0 01 02",
               pc_enable, busy, mem_req, fetch_count, pc);
    end
    tick(2);
    tests++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL halt_pending_stays: got busy=%b req=%b expected 0 0", busy, mem_req);
    end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    tick();
    mem_ready = 1; instr_len = 3'd4;
    tick();
    mem_ready = 0;
    tests++;
    if (pc_enable !== 1'b1) begin
      fails++;
      $display("FAIL reach_step: got en=%b expected 1", pc_enable);
    end
    reset = 0;
    tick();
    tests++;
    if ({pc_clear, pc_enable, mem_req, busy, pc_increment, fetch_count} !== 20'd0) begin
      fails++;
      $display("FAIL reset_in_step: got %h expected 00000",
               {pc_clear, pc_enable, mem_req, busy, pc_increment, fetch_count});
    end
    reset = 1;
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got busy=%b expected 0", busy);
    end
    pulse_start();
    tick();
    start = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (pc_clear !== 1'b0 || mem_req !== 1'b1) begin
        fails++;
        $display("FAIL start_in_fetch[%0d]: got clr=%b req=%b expected 0 1", i, pc_clear, mem_req);
      end
    end
    start = 0;
  endtask

  task automatic test_random();
    int         cnt;
    int         pc_sum;
    int         exp_inc;
    logic [2:0] len;
    logic       bv;
    logic [7:0] off;
    reset = 0;
    tick();
    reset = 1;
    pulse_start();
    tick();
    cnt = 0;
    pc_sum = 0;
    for (int t = 0; t < 40; t++) begin
      int waits;
      waits = $urandom_range(0, 4);
      for (int w = 0; w < waits; w++) begin
        mem_ready = 0;
        start = 1'($urandom_range(0, 1));
        tick();
        tests++;
        if (mem_req !== 1'b1 || pc_clear !== 1'b0) begin
          fails++;
          $display("FAIL rand_wait[%0d]: got req=%b clr=%b expected 1 0", t, mem_req, pc_clear);
        end
      end
      len = 3'($urandom);
      bv  = ($urandom_range(0, 3) == 0);
      off = 8'($urandom);
      start = 1'($urandom_range(0, 1));
      mem_ready = 1; instr_len = len; branch_valid = bv; branch_offset = off;
      tick();
      mem_ready = 0; branch_valid = 0;
      start = 1'($urandom_range(0, 1));
      exp_inc = ref_inc(bv, off, len);
      cnt = cnt + 1;
      tests++;
      if (pc_enable !== 1'b1 || pc_increment !== 8'(exp_inc) || fetch_count !== 8'(cnt)) begin
        fails++;
        $display("FAIL rand_step[%0d]: got en=%b inc=%h cnt=%h expected 1 %h %h",
                 t, pc_enable, pc_increment, fetch_count, 8'(exp_inc), 8'(cnt));
      end
      pc_sum = (pc_sum + exp_inc) % 256;
      tick();
      start = 0;
      tests++;
      if (pc !== 8'(pc_sum) || mem_req !== 1'b1 || pc_clear !== 1'b0) begin
        fails++;
        $display("FAIL rand_pc[%0d]: got pc=%h req=%b clr=%b expected %h 1 0",
                 t, pc, mem_req, pc_clear, 8'(pc_sum));
      end
    end
  endtask

  task automatic test_saturate();
    reset = 0;
    tick();
    reset = 1;
    pulse_start();
    tick();
    mem_ready = 1; instr_len = 3'd1;
    for (int i = 1; i <= 260; i++) begin
      int exp_cnt;
      exp_cnt = (i > 255) ? 255 : i;
      tick();
      tests++;
      if (fetch_count !== 8'(exp_cnt) || pc_enable !== 1'b1) begin
        fails++;
        $display("FAIL sat_count[%0d]: got cnt=%h en=%b expected %h 1",
                 i, fetch_count, pc_enable, 8'(exp_cnt));
      end
      tick();
    end
    mem_ready = 0;
    tests++;
    if (pc !== 8'(260 % 256)) begin
      fails++;
      $display("FAIL pc_wrap: got pc=%h expected %h", pc, 8'(260 % 256));
    end
    halt = 1;
    tick();
    halt = 0;
    tests++;
    if (busy !== 1'b0 || fetch_count !== 8'd255) begin
      fails++;
      $display("FAIL sat_halted: got busy=%b cnt=%h expected 0 ff", busy, fetch_count);
    end
    pulse_start();
    tests++;
    if (pc_clear !== 1'b1 || fetch_count !== 8'd0) begin
      fails++;
      $display("FAIL restart_clear: got clr=%b cnt=%h expected 1 00", pc_clear, fetch_count);
    end
    tick();
    tests++;
    if (pc !== 8'd0 || mem_req !== 1'b1) begin
      fails++;
      $display("FAIL restart_fetch: got pc=%h req=%b expected 00 1", pc, mem_req);
    end
  endtask

`ifdef PC_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    mem_ready = 0;
    tick(14);
    tests++;
    if (mem_req !== 1'b1 || timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_early: got req=%b err=%b expected 1 0", mem_req, timeout_err);
    end
    tick();
    tests++;
    if (timeout_err !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_hit: got err=%b req=%b busy=%b expected 1 0 0", timeout_err, mem_req, busy);
    end
    tick(3);
    tests++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_sticky: got err=%b busy=%b expected 1 0", timeout_err, busy);
    end
    pulse_start();
    tests++;
    if (timeout_err !== 1'b0 || pc_clear !== 1'b1) begin
      fails++;
      $display("FAIL timeout_restart: got err=%b clr=%b expected 0 1", timeout_err, pc_clear);
    end
    tick();
    tick(10);
    mem_ready = 1;
    tick();
    mem_ready = 0;
    tick();
    tick(10);
    tests++;
    if (timeout_err !== 1'b0 || mem_req !== 1'b1) begin
      fails++;
      $display("FAIL wait_counter_rearm: got err=%b req=%b expected 0 1", timeout_err, mem_req);
    end
  endtask
`else
  task automatic test_no_timeout();
    mem_ready = 0;
    tick(40);
    tests++;
    if (mem_req !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL long_wait: got req=%b busy=%b expected 1 1", mem_req, busy);
    end
    mem_ready = 1; instr_len = 3'd7;
    tick();
    mem_ready = 0;
    tests++;
    if (pc_enable !== 1'b1 || pc_increment !== 8'd7) begin
      fails++;
      $display("FAIL long_wait_step: got en=%b inc=%h expected 1 07", pc_enable, pc_increment);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    reset = 0;
    test_reset();
    test_basic();
    test_len_branch();
    test_halt();
    test_reset_mid();
    test_random();
    test_saturate();
`ifdef PC_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
